fifo_access_sched: RTL and testbench

- Scheduler that owns both ports of the team's 16x8 shift-register FIFO.
- Shares the write port among N_REQ producers using round-robin arbitration.
- Serves a single consumer on the read port.
- Never issues a read and a write to the FIFO in the same cycle (the FIFO drops the read when both are asserted). Tracks occupancy itself so that registered write strobes can never overflow the FIFO.

---
 rtl/fifo_access_sched_if.sv | 34 +++
 rtl/fifo_access_sched.sv | 139 +++++++++++++
 tb/tb_fifo_access_sched.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_access_sched_if.sv
// Bundle of producer, consumer and FIFO-port signals owned by fifo_access_sched.
// The slave modport is the scheduler's view; master is the surrounding system.
interface fifo_access_sched_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 5
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic                    rd_req;
    logic                    rd_gnt;
    logic [DATA_W-1:0]       rd_data;
    logic                    rd_valid;
    logic                    fifo_wr_en;
    logic [DATA_W-1:0]       fifo_din;
    logic                    fifo_rd_en;
    logic [DATA_W-1:0]       fifo_dout;
    logic [CNT_W-1:0]        count;
    logic                    sched_full;
    logic                    sched_empty;

    modport slave (
        input  req, wdata, rd_req, fifo_dout,
        output gnt, rd_gnt, rd_data, rd_valid, fifo_wr_en, fifo_din, fifo_rd_en,
               count, sched_full, sched_empty
    );

    modport master (
        output req, wdata, rd_req, fifo_dout,
        input  gnt, rd_gnt, rd_data, rd_valid, fifo_wr_en, fifo_din, fifo_rd_en,
               count, sched_full, sched_empty
    );
endinterface

// File: rtl/fifo_access_sched.sv
// Owns both ports of the shift-register FIFO: round-robin write arbitration among
// N_REQ producers, one consumer, never a read and a write in the same cycle.
module fifo_access_sched #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 5
) (
    input  logic                clk,
    input  logic                reset,
    fifo_access_sched_if.slave  bus
);
    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ISSUE_NONE = 2'd0,
        ISSUE_WR   = 2'd1,
        ISSUE_RD   = 2'd2
    } issue_e;

    typedef enum logic {
        LC_RD = 1'b0,
        LC_WR = 1'b1
    } conflict_e;

    issue_e            issue_q, issue_d;
    conflict_e         last_conflict_q, last_conflict_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] fifo_din_q, fifo_din_d;
    logic              rd_pend_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  cand_idx;
    logic              win_found;
    logic [DATA_W-1:0] win_data;
    logic              wr_cand;
    logic              rd_cand;

    // Round-robin search starting at rr_ptr, wrapping modulo N_REQ
    always_comb begin
        win_idx   = '0;
        cand_idx  = '0;
        win_found = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand_idx = PTR_W'((32'(rr_ptr_q) + k) % N_REQ);
            if (!win_found && bus.req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                win_data = bus.wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign wr_cand = win_found && (count_q < CNT_W'(DEPTH));
    assign rd_cand = bus.rd_req && (count_q != '0);

    // Issue decision; on a tie, alternate against the last conflict winner
    always_comb begin
        issue_d         = ISSUE_NONE;
        last_conflict_d = last_conflict_q;
        if (wr_cand && rd_cand) begin
            if (last_conflict_q == LC_RD) begin
                issue_d         = ISSUE_WR;
                last_conflict_d = LC_WR;
            end else begin
                issue_d         = ISSUE_RD;
                last_conflict_d = LC_RD;
            end
        end else if (wr_cand) begin
            issue_d = ISSUE_WR;
        end else if (rd_cand) begin
            issue_d = ISSUE_RD;
        end
    end

    always_comb begin
        count_d    = count_q;
        rr_ptr_d   = rr_ptr_q;
        fifo_din_d = fifo_din_q;
        case (issue_d)
            ISSUE_WR: begin
                count_d    = count_q + CNT_W'(1);
                rr_ptr_d   = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
                fifo_din_d = win_data;
            end
            ISSUE_RD: begin
                count_d = count_q - CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_q         <= ISSUE_NONE;
            last_conflict_q <= LC_RD;
            count_q         <= '0;
            rr_ptr_q        <= '0;
            fifo_din_q      <= '0;
            rd_pend_q       <= 1'b0;
            rd_valid_q      <= 1'b0;
            rd_data_q       <= '0;
        end else begin
            issue_q         <= issue_d;
            last_conflict_q <= last_conflict_d;
            count_q         <= count_d;
            rr_ptr_q        <= rr_ptr_d;
            fifo_din_q      <= fifo_din_d;
            rd_pend_q       <= (issue_d == ISSUE_RD);
            rd_valid_q      <= rd_pend_q;
            // FIFO head is still the read entry during the strobe cycle
            if (rd_pend_q) begin
                rd_data_q <= bus.fifo_dout;
            end
        end
    end

    assign bus.gnt         = (!reset && issue_d == ISSUE_WR) ? (N_REQ'(1) << win_idx) : '0;
    assign bus.rd_gnt      = !reset && (issue_d == ISSUE_RD);
    assign bus.fifo_wr_en  = (issue_q == ISSUE_WR);
    assign bus.fifo_rd_en  = (issue_q == ISSUE_RD);
    assign bus.fifo_din    = fifo_din_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.count       = count_q;
    assign bus.sched_full  = (count_q == CNT_W'(DEPTH));
    assign bus.sched_empty = (count_q == '0);
endmodule

// File: tb/tb_fifo_access_sched.sv
// Bench for fifo_access_sched with a behavioural 16x8 shift-register FIFO on the far side.
module tb_fifo_access_sched;
    localparam int unsigned N_REQ  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned CNT_W  = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fifo_access_sched_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    fifo_access_sched #(.N_REQ(N_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    // Shift-register FIFO model: head visible on dout, synchronous reset
    logic [7:0] fmem [DEPTH];
    int fcnt = 0;
    int fifo_err = 0;
    assign bus.fifo_dout = fmem[0];

    always @(posedge clk) begin
        if (reset) begin
            fcnt <= 0;
            for (int i = 0; i < DEPTH; i++) fmem[i] <= 8'h00;
        end else if (bus.fifo_wr_en && bus.fifo_rd_en) begin
            fifo_err <= fifo_err + 1;
            $display("FAIL fifo_port: wr_en and rd_en both high at %0t, required exclusive", $time);
        end else if (bus.fifo_wr_en) begin
            if (fcnt == DEPTH) begin
                fifo_err <= fifo_err + 1;
                $display("FAIL fifo_overflow: write with %0d entries, required < %0d", fcnt, DEPTH);
            end else begin
                fmem[fcnt] <= bus.fifo_din;
                fcnt <= fcnt + 1;
            end
        end else if (bus.fifo_rd_en) begin
            if (fcnt == 0) begin
                fifo_err <= fifo_err + 1;
                $display("FAIL fifo_underflow: read with 0 entries, required > 0");
            end else begin
                for (int i = 0; i < DEPTH - 1; i++) fmem[i] <= fmem[i+1];
                fmem[DEPTH-1] <= 8'h00;
                fcnt <= fcnt - 1;
            end
        end
    end

    typedef struct {
        logic [3:0] req;
        logic       rd_req;
        logic [3:0] exp_gnt;
        logic       exp_rd_gnt;
        string      name;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = '0;
        bus.rd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
    endtask

    // Present a request pattern for one cycle, check grants, withdraw before the edge
    task automatic check_comb(input string nm, input logic [3:0] r, input logic rr,
                              input logic [3:0] eg, input logic erg);
        cyc();
        bus.req = r;
        bus.rd_req = rr;
        @(negedge clk);
        check({nm, "_gnt"}, 32'(bus.gnt), 32'(eg));
        check({nm, "_rd_gnt"}, 32'(bus.rd_gnt), 32'(erg));
        #1;
        bus.req = '0;
        bus.rd_req = 1'b0;
    endtask

    task automatic fill_n(input int p, input int n, output int got);
        got = 0;
        cyc();
        bus.wdata = {8'h53, 8'h52, 8'h51, 8'h50};
        bus.req = 4'(1 << p);
        for (int c = 0; c < 4 * n + 8 && got < n; c++) begin
            @(negedge clk);
            if (bus.gnt[p[1:0]]) got++;
            @(posedge clk);
            #1;
            if (got >= n) bus.req = '0;
        end
        bus.req = '0;
    endtask

    // Hold rd_req and score returned data against exp_q
    task automatic drain(input string nm, input int n_exp);
        int first_gnt, first_val, last_val, nval;
        first_gnt = -1; first_val = -1; last_val = -1; nval = 0;
        cyc();
        bus.rd_req = 1'b1;
        for (int c = 0; c < n_exp + 8; c++) begin
            @(negedge clk);
            if (bus.rd_gnt && first_gnt < 0) first_gnt = c;
            if (bus.rd_valid) begin
                if (first_val < 0) first_val = c;
                last_val = c;
                nval++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL %s_extra: rd_valid with data %0h, required no data", nm, bus.rd_data);
                end else begin
                    check({nm, "_data"}, 32'(bus.rd_data), 32'(exp_q.pop_front()));
                end
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check({nm, "_nvalid"}, 32'(nval), 32'(n_exp));
        check({nm, "_latency"}, 32'(first_val - first_gnt), 32'd2);
        check({nm, "_b2b"}, 32'(last_val - first_val), 32'(n_exp - 1));
        check({nm, "_count"}, 32'(bus.count), 32'd0);
        check({nm, "_empty_rd_gnt"}, 32'(bus.rd_gnt), 32'd0);
        check({nm, "_sched_empty"}, 32'(bus.sched_empty), 32'd1);
        #1 bus.rd_req = 1'b0;
    endtask

    initial begin
        int got, nwr, gnt_full, bad;
        logic [3:0] r, eg;
        logic [7:0] val;

        vecs[0] = '{4'b0001, 1'b0, 4'b0001, 1'b0, "v_single0"};
        vecs[1] = '{4'b0110, 1'b0, 4'b0010, 1'b0, "v_lowest_from0"};
        vecs[2] = '{4'b1000, 1'b1, 4'b1000, 1'b0, "v_wr_rd_empty"};
        vecs[3] = '{4'b1100, 1'b0, 4'b0100, 1'b0, "v_pair23"};
        vecs[4] = '{4'b0000, 1'b1, 4'b0000, 1'b0, "v_rd_empty"};
        vecs[5] = '{4'b0000, 1'b0, 4'b0000, 1'b0, "v_idle"};

        // Reset state, with requests asserted to confirm grant gating
        bus.req = 4'b1111;
        bus.wdata = '0;
        bus.rd_req = 1'b1;
        @(negedge clk);
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_rd_gnt", 32'(bus.rd_gnt), 32'd0);
        check("rst_strobes", 32'({bus.fifo_wr_en, bus.fifo_rd_en, bus.rd_valid}), 32'd0);
        check("rst_data", 32'({bus.fifo_din, bus.rd_data}), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_flags", 32'({bus.sched_full, bus.sched_empty}), 32'b01);
        bus.req = '0;
        bus.rd_req = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;

        // Idle with rd_req held on an empty scheduler
        bus.rd_req = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rd_gnt || bus.fifo_rd_en || bus.rd_valid) bad++;
        end
        check("idle_rd_gnt", 32'(bad), 32'd0);
        check("idle_count", 32'(bus.count), 32'd0);
        #1 bus.rd_req = 1'b0;

        for (int i = 0; i < 6; i++)
            check_comb(vecs[i].name, vecs[i].req, vecs[i].rd_req, vecs[i].exp_gnt, vecs[i].exp_rd_gnt);

        // Fairness: all four producers together, each drops after its grant
        cyc();
        bus.wdata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        r = 4'b1111;
        bus.req = r;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            eg = (k < 4) ? 4'(1 << k) : 4'b0000;
            check("fair_gnt", 32'(bus.gnt), 32'(eg));
            if (k >= 1 && k <= 4) begin
                check("fair_wr_en", 32'(bus.fifo_wr_en), 32'd1);
                check("fair_din", 32'(bus.fifo_din), 32'(8'hA0 + 8'(k - 1)));
            end
            @(posedge clk);
            #1;
            if (k < 4) r[k] = 1'b0;
            bus.req = r;
        end
        @(negedge clk);
        check("fair_count", 32'(bus.count), 32'd4);
        exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
        check_comb("rr_wrap", 4'b1001, 1'b0, 4'b0001, 1'b0);
        drain("fair_drain", 4);

        // Fill from empty through producer 2 with an incrementing value
        do_reset();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h10 + i));
        val = 8'h10;
        nwr = 0;
        gnt_full = 0;
        bus.wdata = '0;
        bus.wdata[2*8 +: 8] = val;
        bus.req = 4'b0100;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (bus.fifo_wr_en) nwr++;
            if (bus.gnt != 4'b0000 && bus.sched_full) gnt_full++;
            got = int'(bus.gnt[2]);
            @(posedge clk);
            #1;
            if (got != 0) val = val + 8'h01;
            bus.wdata[2*8 +: 8] = val;
        end
        @(negedge clk);
        check("fill_wr_pulses", 32'(nwr), 32'd16);
        check("fill_gnt_while_full", 32'(gnt_full), 32'd0);
        check("fill_gnt_held_off", 32'(bus.gnt), 32'd0);
        check("fill_count", 32'(bus.count), 32'd16);
        check("fill_full", 32'(bus.sched_full), 32'd1);
        check("fill_fifo_occ", 32'(fcnt), 32'd16);
        #1 bus.req = '0;
        drain("fill_drain", 16);
        check_comb("rr_from3", 4'b1100, 1'b0, 4'b1000, 1'b0);

        // Conflict: write and read held together at count 5
        do_reset();
        fill_n(1, 5, got);
        check("conf_prefill", 32'(got), 32'd5);
        @(negedge clk);
        check("conf_count0", 32'(bus.count), 32'd5);
        cyc();
        bus.req = 4'b0010;
        bus.rd_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("conf_gnt", 32'(bus.gnt), (k % 2 == 0) ? 32'b0010 : 32'd0);
            check("conf_rd_gnt", 32'(bus.rd_gnt), (k % 2 == 0) ? 32'd0 : 32'd1);
            check("conf_excl", 32'(bus.fifo_wr_en & bus.fifo_rd_en), 32'd0);
            check("conf_count", 32'(bus.count), (k % 2 == 0) ? 32'd5 : 32'd6);
        end
        #1;
        bus.req = '0;
        bus.rd_req = 1'b0;

        // Asynchronous reset between edges during a drain
        do_reset();
        fill_n(0, 8, got);
        check("arst_prefill", 32'(got), 32'd8);
        cyc();
        bus.rd_req = 1'b1;
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            @(negedge clk);
            if (bus.rd_valid) got = 1;
        end
        check("arst_first_valid", 32'(got), 32'd1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_strobes", 32'({bus.fifo_wr_en, bus.fifo_rd_en, bus.rd_valid, bus.rd_gnt}), 32'd0);
        check("arst_rd_data", 32'(bus.rd_data), 32'd0);
        check("arst_count", 32'(bus.count), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rd_valid || bus.rd_gnt) bad++;
        end
        check("arst_no_valid", 32'(bad), 32'd0);
        check("arst_count_after", 32'(bus.count), 32'd0);
        check("arst_fifo_cleared", 32'(fcnt), 32'd0);
        bus.rd_req = 1'b0;

        check("fifo_protocol", 32'(fifo_err), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
